// File: rtl/pipe_skid_reg_pkg.sv
// Shared definitions for the pipeline skid register: occupancy state codes,
// the occupancy bus width and a helper mapping state to occupancy.
package pipe_skid_reg_pkg;

    localparam int PIPE_CNT_W = 2;

    typedef enum logic [1:0] {
        PIPE_ST_EMPTY = 2'd0,
        PIPE_ST_ONE   = 2'd1,
        PIPE_ST_TWO   = 2'd2
    } pipe_st_e;

    // Number of beats held in a given state.
    function automatic logic [PIPE_CNT_W-1:0] pipe_occupancy(input pipe_st_e st);
        logic [PIPE_CNT_W-1:0] occ;
        case (st)
            PIPE_ST_ONE: occ = 2'd1;
            PIPE_ST_TWO: occ = 2'd2;
            default:     occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_skid_reg.sv
// Two-entry skid-buffered pipeline register with a registered in_ready,
// synchronous flush, bubble value while empty and a sticky sideband field.
// The head entry (main) always leaves before the skid entry, so order is kept.
module pipe_skid_reg
    import pipe_skid_reg_pkg::*;
#(
    parameter int               WIDTH  = 32,
    parameter int               SIDE_W = 1,
    parameter logic [WIDTH-1:0] BUBBLE = {WIDTH{1'b0}}
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  in_ready,
    input  logic [SIDE_W-1:0]     side_i,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    input  logic                  out_ready,
    output logic [SIDE_W-1:0]     side_o,
    output logic [PIPE_CNT_W-1:0] count
);

    pipe_st_e         state;
    pipe_st_e         state_nxt;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             in_fire;
    logic             out_fire;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // State register; reset clears the held beats immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= PIPE_ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; flush overrides every transition.
    always_comb begin
        state_nxt = state;
        case (state)
            PIPE_ST_EMPTY: begin
                if (in_fire) state_nxt = PIPE_ST_ONE;
            end
            PIPE_ST_ONE: begin
                if (in_fire && !out_fire)      state_nxt = PIPE_ST_TWO;
                else if (out_fire && !in_fire) state_nxt = PIPE_ST_EMPTY;
            end
            PIPE_ST_TWO: begin
                if (out_fire) state_nxt = PIPE_ST_ONE;
            end
            default: state_nxt = PIPE_ST_EMPTY;
        endcase
        if (flush) state_nxt = PIPE_ST_EMPTY;
    end

    // Outputs decoded from the current state; bubble shown while empty.
    always_comb begin
        out_valid = (state != PIPE_ST_EMPTY);
        out_data  = out_valid ? main_q : BUBBLE;
        count     = pipe_occupancy(state);
    end

    // Registered ready: low exactly when the next cycle holds two beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready <= 1'b1;
        end else begin
            in_ready <= (state_nxt != PIPE_ST_TWO);
        end
    end

    // Payload entries; loaded only on accepted/consumed beats, untouched on flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q <= BUBBLE;
            skid_q <= BUBBLE;
        end else if (!flush) begin
            case (state)
                PIPE_ST_EMPTY: begin
                    if (in_fire) main_q <= in_data;
                end
                PIPE_ST_ONE: begin
                    if (in_fire && out_fire) main_q <= in_data;
                    else if (in_fire)        skid_q <= in_data;
                end
                PIPE_ST_TWO: begin
                    if (out_fire) main_q <= skid_q;
                end
                default: ;
            endcase
        end
    end

    // Sticky sideband: follows accepted beats only, flush leaves it alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            side_o <= '0;
        end else if (in_fire) begin
            side_o <= side_i;
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Testbench for pipe_skid_reg: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based model of the buffer contents.
module tb_pipe_skid_reg;

    localparam int               W   = 32;
    localparam int               SW  = 1;
    localparam logic [W-1:0]     BUB = 32'hDEAD_BEEF;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          in_ready;
    logic [SW-1:0] side_i;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          out_ready;
    logic [SW-1:0] side_o;
    logic [1:0]    count;

    int checks = 0;
    int errors = 0;

    // Model: the ordered list of beats held, plus the last accepted sideband.
    logic [W-1:0]  q[$];
    logic [SW-1:0] side_m;

    pipe_skid_reg #(.WIDTH(W), .SIDE_W(SW), .BUBBLE(BUB)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .side_i    (side_i),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .side_o    (side_o),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_outs();
        chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
        chk("out_data",  64'(out_data),  64'((q.size() > 0) ? q[0] : BUB));
        chk("in_ready",  64'(in_ready),  64'(q.size() < 2));
        chk("count",     64'(count),     64'(q.size()));
        chk("side_o",    64'(side_o),    64'(side_m));
    endtask

    // One clock: drive inputs, check at negedge, advance the model at posedge.
    task automatic cycle(input logic v, input logic [W-1:0] d, input logic [SW-1:0] s,
                         input logic r, input logic f);
        bit ifire;
        bit ofire;
        in_valid  = v;
        in_data   = d;
        side_i    = s;
        out_ready = r;
        flush     = f;
        @(negedge clk);
        check_outs();
        ifire = v && (q.size() < 2);
        ofire = (q.size() > 0) && r;
        @(posedge clk);
        if (f) begin
            q.delete();
        end else begin
            if (ofire) void'(q.pop_front());
            if (ifire) q.push_back(d);
        end
        if (ifire) side_m = s;
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0;
        side_i = '0; out_ready = 1'b0;
        side_m = '0;
        #3;
        check_outs();
        chk("rst_out_data", 64'(out_data), 64'(BUB));
        @(posedge clk); #1;
        rst = 1'b0;

        // Streaming with out_ready high
        cycle(1'b1, 32'h11, 1'b0, 1'b1, 1'b0);
        chk("stream_0", 64'(out_data), 64'h11);
        cycle(1'b1, 32'h22, 1'b0, 1'b1, 1'b0);
        chk("stream_1", 64'(out_data), 64'h22);
        cycle(1'b1, 32'h33, 1'b0, 1'b1, 1'b0);
        chk("stream_2", 64'(out_data), 64'h33);
        chk("stream_cnt", 64'(count), 64'd1);
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

        // Backpressure fill then drain
        cycle(1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
        chk("bp_ready", 64'(in_ready), 64'd0);
        cycle(1'b1, 32'hC, 1'b0, 1'b0, 1'b0);
        chk("bp_cnt", 64'(count), 64'd2);
        chk("bp_head", 64'(out_data), 64'hA);
        cycle(1'b1, 32'hC, 1'b0, 1'b1, 1'b0);
        chk("drain_b", 64'(out_data), 64'hB);
        cycle(1'b1, 32'hC, 1'b0, 1'b1, 1'b0);
        chk("drain_c", 64'(out_data), 64'hC);
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        chk("drain_empty", 64'(out_valid), 64'd0);

        // Flush while full with a beat offered
        cycle(1'b1, 32'h1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 32'h2, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 32'hDD, 1'b1, 1'b0, 1'b1);
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_data", 64'(out_data), 64'(BUB));
        chk("flush_side", 64'(side_o), 64'd1);
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

        // Sticky sideband across idle and flush
        cycle(1'b1, 32'h5, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        chk("sticky_side", 64'(side_o), 64'd1);
        cycle(1'b1, 32'h7, 1'b0, 1'b0, 1'b1);
        chk("flush_accept_side", 64'(side_o), 64'd0);
        chk("flush_drop", 64'(count), 64'd0);

        // Asynchronous reset between edges while full
        cycle(1'b1, 32'h8, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 32'h9, 1'b1, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        q.delete();
        side_m = '0;
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_cnt", 64'(count), 64'd0);
        chk("arst_ready", 64'(in_ready), 64'd1);
        check_outs();
        @(posedge clk); #1;
        rst = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 10000; i++) begin
            cycle(($urandom % 4) != 0, $urandom, SW'($urandom), ($urandom % 3) != 0,
                  ($urandom % 32) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Parametrised pipeline stage register that succeeds the fixed-field inter-stage latches. It carries an arbitrary-width payload between two pipeline stages using a valid/ready handshake with a two-entry skid buffer, so that the upstream stage sees a registered `in_ready` and the pipe still sustains full throughput. It adds a synchronous flush, a configurable bubble value driven while empty, and a sticky sideband field that survives flushes. It is instantiated between any two stages (IF/ID, ID/EX, EX/MEM, MEM/WB) in place of per-stage hand-written registers.

## Interface
- `WIDTH`, 32 — payload width in bits
- `SIDE_W`, 1 — sticky sideband width; the sideband updates only on accepted beats and is never flushed
- `BUBBLE`, {WIDTH{1'b0}} — value driven on `out_data` whenever `out_valid`=0
- `clk`  in  1  — clock, rising edge
- `rst`  in  1  — reset; one clock; reset is asynchronous and active-high
- `flush`  in  1  — synchronous kill of all held beats
- `in_valid`  in  1  — upstream beat present
- `in_data`  in  WIDTH  — upstream payload
- `in_ready`  out  1  — registered; high when the skid entry is empty
- `side_i`  in  SIDE_W  — sticky sideband input, captured on an accepted beat
- `out_valid`  out  1  — downstream beat present
- `out_data`  out  WIDTH  — head payload, or `BUBBLE` when not valid
- `out_ready`  in  1  — downstream accepts
- `side_o`  out  SIDE_W  — last captured sideband
- `count`  out  2  — occupancy, 0..2

## Operation
- `in_fire` = `in_valid & in_ready`; `out_fire` = `out_valid & out_ready`.
- Storage: `main` (head) and `skid`. States are EMPTY, ONE and TWO; `count` equals the state's occupancy.
- EMPTY: on `in_fire`, `main`<=`in_data` and the state goes to ONE.
- ONE:
  - `in_fire & out_fire`: `main`<=`in_data`, stay in ONE.
  - `out_fire` only: go to EMPTY.
  - `in_fire` only: `skid`<=`in_data`, go to TWO.
  - Otherwise hold.
- TWO (`in_ready`=0):
  - On `out_fire`: `main`<=`skid`, go to ONE.
  - Otherwise hold.
- Order is preserved: the `main` beat always leaves before the `skid` beat.
- `out_valid` = (state != EMPTY). `out_data` = `main` when valid, else `BUBBLE`.
- `in_ready` is registered: next value = (next state != TWO).
- Payload registers do not change while held; no data is ever lost or duplicated.
- `flush` has highest priority:
  - Next state is EMPTY, `in_ready`<=1.
  - A beat offered in the same cycle is dropped.
  - A downstream `out_fire` in the flush cycle still counts as consumed.
- `side_o`<=`side_i` on every `in_fire`, including in the flush cycle. `flush` does not touch `side_o`.

## Timing
- Reset values (asynchronous): state EMPTY, `out_valid`=0, `out_data`=`BUBBLE`, `in_ready`=1, `count`=0, `side_o`=0, `main`/`skid`=`BUBBLE`.
- First rising edge after `rst` deasserts may accept a beat.
- Latency: a beat accepted at edge N is visible on `out_data` after edge N.
- Throughput: one beat per cycle when `out_ready` is held high; `in_ready` never drops in that case.
- Backpressure: with `out_ready` low and `in_valid` high from EMPTY:
  - `in_ready` is 1, 1, then 0 for the following cycles.
  - Exactly two beats are accepted.
- `in_ready` rises the cycle after the `out_fire` that leaves TWO.
- `rst` mid-transfer discards all beats immediately (combinationally on assertion), not at the next edge.
- `in_valid` low with `in_ready` high is idle; `in_data` is ignored.

## Structure
- Shared `define.v` gains:
  - `PipeStEmpty`/`PipeStOne`/`PipeStTwo` (2-bit state codes).
  - `PipeCntBus` (1:0).
- Payload bundling stays at the instantiation site: the ID/EX instance concatenates aluop, alusel, reg1, reg2, wd, wreg, link address, delay-slot flag and inst into `in_data`. `side_i` carries next-instruction-in-delay-slot.
- No sub-module: the two entries, the FSM and the registered ready fit in one module.

## Test plan
- Reset then stream: `out_ready`=1, push 0x11, 0x22, 0x33 on consecutive cycles -> `out_data` shows 0x11, 0x22, 0x33 on consecutive cycles, `in_ready` constantly 1, `count` = 1.
- Backpressure fill: `out_ready`=0, offer 0xA, 0xB, 0xC -> 0xA and 0xB accepted, `in_ready`=0 on the third cycle, `count`=2. Release `out_ready` -> 0xA, 0xB, 0xC exit in order with no duplicates.
- Flush in TWO with `in_valid`=1 (0xDD) and `side_i`=1 -> next cycle `out_valid`=0, `out_data`=`BUBBLE`, `count`=0, `in_ready`=1, `side_o`=1; 0xDD never appears.
- Sticky sideband: accept a beat with `side_i`=1, then idle with `side_i`=0 and flush -> `side_o` stays 1 until the next accepted beat.
- Async reset mid-TWO: assert `rst` between edges -> `out_valid`=0, `count`=0 and `in_ready`=1 before the next edge.
- Random valid/ready (10k cycles, scoreboard) -> output sequence equals accepted input sequence, and `out_data`=`BUBBLE` whenever `out_valid`=0.
